// File: rtl/boot_loader.sv
// Program loader and reset sequencer: streams words into instruction memory
// from address 0, holds the core in reset while loading and for HOLD_CYCLES after.
module boot_loader #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_resetb,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(1) << ADDR_W;

  state_t              state_reg, state_next;
  logic [ADDR_W:0]     len_reg;
  logic [ADDR_W:0]     count_reg;
  logic [HC_W-1:0]     hold_cnt_reg;
  logic                s_ready_reg, mem_we_reg, core_resetb_reg;
  logic                busy_reg, done_reg, err_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg, checksum_reg;
  logic                hs, start_ok, start_bad;

  always_comb begin
    state_next = state_reg;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    hs         = s_ready_reg & s_valid;
    case (state_reg)
      IDLE, RUN: begin
        if (start) begin
          if (len > LEN_MAX) begin
            start_bad = 1'b1;
          end else begin
            start_ok   = 1'b1;
            state_next = (len == '0) ? HOLD : LOAD;
          end
        end
      end
      LOAD: begin
        // Leave on the handshake of the final word; its write lands in the first HOLD cycle.
        if (hs && (count_reg == len_reg - (ADDR_W+1)'(1))) state_next = HOLD;
      end
      HOLD: begin
        if (hold_cnt_reg == HC_W'(HOLD_CYCLES - 1)) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      len_reg         <= '0;
      count_reg       <= '0;
      hold_cnt_reg    <= '0;
      s_ready_reg     <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      core_resetb_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      checksum_reg    <= '0;
    end else begin
      state_reg <= state_next;
      mem_we_reg <= hs;
      if (hs) begin
        mem_addr_reg  <= count_reg[ADDR_W-1:0];
        mem_wdata_reg <= s_data;
        checksum_reg  <= checksum_reg + s_data;
        count_reg     <= count_reg + (ADDR_W+1)'(1);
      end
      if (start_ok) begin
        len_reg      <= len;
        count_reg    <= '0;
        checksum_reg <= '0;
        err_reg      <= 1'b0;
      end
      if (start_bad) err_reg <= 1'b1;
      hold_cnt_reg    <= (state_reg == HOLD) ? hold_cnt_reg + HC_W'(1) : '0;
      // Outputs are decoded from the next state so they change together with it.
      s_ready_reg     <= (state_next == LOAD);
      busy_reg        <= (state_next == LOAD) || (state_next == HOLD);
      core_resetb_reg <= (state_next == RUN);
      done_reg        <= (state_next == RUN) && (state_reg != RUN);
    end
  end

  assign s_ready     = s_ready_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign core_resetb = core_resetb_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign checksum    = checksum_reg;

endmodule

// File: tb/tb_boot_loader.sv
// Directed and randomized bench for boot_loader, checked against a word-queue /
// running-sum model of the load and reset-release sequence.
module tb_boot_loader;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int HOLD_CYCLES = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready, mem_we, core_resetb, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, checksum;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] words[$];

  boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_resetb(core_resetb), .busy(busy), .done(done), .err(err),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode: 0 = valid every cycle, 1 = valid every other cycle, 2 = random valid
  task automatic do_load(input int mode);
    int n, k, cyc;
    logic [DATA_W-1:0] sum;
    logic exp_we, v;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    n = words.size();
    start = 1'b1;
    len = (ADDR_W+1)'(n);
    step();
    start = 1'b0;
    chk("start_resetb", core_resetb, 0);
    chk("start_err", err, 0);
    chk("start_sum", checksum, 0);
    k = 0; sum = '0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    for (cyc = 0; cyc < 8000; cyc++) begin
      chk("we", mem_we, exp_we);
      if (exp_we) begin
        chk("addr", mem_addr, exp_addr);
        chk("wdata", mem_wdata, exp_data);
        chk("sum", checksum, sum);
      end
      if (k == n) break;
      chk("ready", s_ready, 1);
      chk("load_busy", busy, 1);
      chk("load_resetb", core_resetb, 0);
      case (mode)
        0: v = 1'b1;
        1: v = cyc[0];
        default: v = ($urandom_range(99) < 60);
      endcase
      s_valid = v;
      s_data = v ? words[k] : DATA_W'($urandom);
      exp_we = v;
      if (v) begin
        exp_addr = ADDR_W'(k);
        exp_data = words[k];
        sum = sum + words[k];
        k++;
      end
      step();
    end
    if (cyc >= 8000) begin
      chk("load_timeout", 1, 0);
      return;
    end
    s_valid = 1'b0;
    chk("ready_off", s_ready, 0);
    for (int i = 0; i < HOLD_CYCLES; i++) begin
      if (i > 0) chk("hold_we", mem_we, 0);
      chk("hold_busy", busy, 1);
      chk("hold_resetb", core_resetb, 0);
      chk("hold_done", done, 0);
      step();
    end
    chk("run_done", done, 1);
    chk("run_resetb", core_resetb, 1);
    chk("run_busy", busy, 0);
    chk("run_sum", checksum, sum);
    chk("run_we", mem_we, 0);
    step();
    chk("done_pulse", done, 0);
    chk("run_resetb2", core_resetb, 1);
    chk("run_sum2", checksum, sum);
    $display("load n=%0d mode=%0d checksum=%08h", n, mode, sum);
  endtask

  task automatic illegal_start(input logic exp_resetb);
    start = 1'b1;
    len = (ADDR_W+1)'(1025);
    step();
    start = 1'b0;
    chk("ill_err", err, 1);
    chk("ill_busy", busy, 0);
    chk("ill_ready", s_ready, 0);
    chk("ill_resetb", core_resetb, exp_resetb);
    step();
    chk("ill_err_sticky", err, 1);
    chk("ill_resetb2", core_resetb, exp_resetb);
    $display("illegal start len=1025 err=%0b", err);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0; s_data = '0;
    step(); step();
    chk("rst_ready", s_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_resetb", core_resetb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sum", checksum, 0);
    reset = 1'b0;
    step();

    // illegal length from IDLE, then a legal single-word load clears err
    illegal_start(1'b0);
    words = '{32'hABCD_0001};
    do_load(0);

    // four NOP words back-to-back
    words = '{32'h13, 32'h13, 32'h13, 32'h13};
    do_load(0);
    chk("nop_sum", checksum, 32'h4C);

    // gapped stream, empty load, wrap-around checksum from RUN
    words = '{32'h1111, 32'h2222, 32'h3333};
    do_load(1);
    words = {};
    do_load(0);
    words = '{32'hFFFF_FFFF, 32'h2};
    do_load(0);
    chk("wrap_sum", checksum, 32'h1);

    // illegal length while running keeps the core running
    illegal_start(1'b1);

    // random lengths and gaps
    for (int t = 0; t < 6; t++) begin
      words = {};
      for (int i = 0, nn = $urandom_range(1, 24); i < nn; i++) words.push_back(DATA_W'($urandom));
      do_load(2);
    end

    // full memory: last address is 2^ADDR_W-1
    words = {};
    for (int i = 0; i < (1 << ADDR_W); i++) words.push_back(DATA_W'($urandom));
    do_load(0);
    chk("full_last_addr", mem_addr, (1 << ADDR_W) - 1);

    // reset in the middle of a load
    start = 1'b1; len = (ADDR_W+1)'(4);
    step();
    start = 1'b0; s_valid = 1'b1; s_data = 32'h55;
    step();
    step();
    reset = 1'b1;
    step();
    chk("mid_ready", s_ready, 0);
    chk("mid_we", mem_we, 0);
    chk("mid_addr", mem_addr, 0);
    chk("mid_wdata", mem_wdata, 0);
    chk("mid_resetb", core_resetb, 0);
    chk("mid_busy", busy, 0);
    chk("mid_sum", checksum, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_we", mem_we, 0);
      chk("post_rst_ready", s_ready, 0);
    end
    s_valid = 1'b0;
    $display("mid-load reset: outputs at reset values");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
